// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock FIFO for queued UART words; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word input, LSB-first frame with
// optional parity and 1/2 stop bits. Define UART_TX_FIFO_EN for an input FIFO.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 Dout,
  output logic                 Busy
);

  localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BAUD_W = $clog2(CPB);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

  if (CPB < 2) begin : g_bad_baud
    $error("CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
    $error("DATA_BITS must be within 5..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  tx_state_e            state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 stop2_q;
  logic                 dout_q;
  logic                 busy_q;
  logic                 dout_d;

  logic                 bit_end;
  logic                 stop_end;
  logic                 can_load;
  logic                 load;
  logic [DATA_BITS-1:0] ld_data;
  logic [1:0]           ld_mode;
  logic                 ld_stop2;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign stop_end = (state_q == STOP) && bit_end &&
                    (bit_q == (stop2_q ? BIT_W'(1) : BIT_W'(0)));
  assign can_load = !RST && ((state_q == IDLE) || stop_end);

`ifdef UART_TX_FIFO_EN
  logic [DATA_BITS+2:0] fifo_out;
  logic                 fifo_full;
  logic                 fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS + 3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (tx_valid && tx_ready),
    .data_i  ({stop2, parity_mode, tx_data}),
    .pop_i   (load),
    .data_o  (fifo_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_ready = !RST && !fifo_full;
  assign load     = can_load && !fifo_empty;
  assign {ld_stop2, ld_mode, ld_data} = fifo_out;
`else
  // Ready on the last stop cycle lets a waiting word start with no gap.
  assign tx_ready = can_load;
  assign load     = tx_valid && can_load;
  assign ld_data  = tx_data;
  assign ld_mode  = parity_mode;
  assign ld_stop2 = stop2;
`endif

  always_ff @(posedge CLK) begin
    if (load) begin
      shift_q   <= ld_data;
      par_en_q  <= (ld_mode == PAR_ODD) || (ld_mode == PAR_EVEN);
      par_bit_q <= (ld_mode == PAR_ODD) ? ~^ld_data : ^ld_data;
      stop2_q   <= ld_stop2;
    end else if (state_q == DATA && bit_end) begin
      shift_q <= shift_q >> 1;
    end
  end

  always_comb begin
    dout_d = 1'b1;
    case (state_q)
      START:   dout_d = 1'b0;
      DATA:    dout_d = shift_q[0];
      PARITY:  dout_d = par_bit_q;
      default: dout_d = 1'b1;
    endcase
  end

  // Line outputs follow the state register by one cycle, so every bit on
  // Dout is exactly one state period long and Dout is purely registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      dout_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      busy_q <= (state_q != IDLE);
      baud_q <= bit_end ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (load) state_q <= START;
        end
        START: if (bit_end) state_q <= DATA;
        DATA: if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_q   <= '0;
            state_q <= par_en_q ? PARITY : STOP;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        PARITY: if (bit_end) state_q <= STOP;
        STOP: if (bit_end) begin
          if (stop_end) begin
            bit_q   <= '0;
            state_q <= load ? START : IDLE;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Dout = dout_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: an 8-bit and a 7-bit instance at 16 clocks/bit.
module tb_uart_tx_param;

  localparam int CPB = 16;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          acc;
  } frame_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] d0 = '0;
  logic [6:0] d1 = '0;
  logic [1:0] pm0 = '0, pm1 = '0;
  logic       st0 = 1'b0, st1 = 1'b0, v0 = 1'b0, v1 = 1'b0;
  logic       rdy0, rdy1, dout0, dout1, busy0, busy1;
  logic [1:0] line, busyv, rdy;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int last_acc = 0;
  frame_t q0[$];
  frame_t q1[$];

  assign line  = {dout1, dout0};
  assign busyv = {busy1, busy0};
  assign rdy   = {rdy1, rdy0};

  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0),
    .parity_mode(pm0), .stop2(st0), .Dout(dout0), .Busy(busy0)
  );

  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .FIFO_DEPTH(4)) dut7 (
    .CLK(CLK), .RST(RST), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
    .parity_mode(pm1), .stop2(st1), .Dout(dout1), .Busy(busy1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endfunction

  // Reference frame built from the line format: start, LSB-first data,
  // parity from a count of ones, then stop bits.
  function automatic frame_t model(input int data, input int nb, input int pm,
                                   input bit st2, input int acc);
    frame_t f;
    int n = 0;
    int ones = 0;
    f.bits = '0;
    f.bits[n] = 1'b0; n = n + 1;
    for (int i = 0; i < nb; i++) begin
      f.bits[n] = ((data >> i) & 1) != 0;
      ones = ones + ((data >> i) & 1);
      n = n + 1;
    end
    if (pm == 1) begin f.bits[n] = (ones % 2) == 0; n = n + 1; end
    if (pm == 2) begin f.bits[n] = (ones % 2) == 1; n = n + 1; end
    f.bits[n] = 1'b1; n = n + 1;
    if (st2) begin f.bits[n] = 1'b1; n = n + 1; end
    f.nbits = n;
    f.acc = acc;
    return f;
  endfunction

  function automatic int q_size(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction
  function automatic frame_t q_pop(input int u);
    return (u == 0) ? q0.pop_front() : q1.pop_front();
  endfunction
  function automatic void q_push(input int u, input frame_t f);
    if (u == 0) q0.push_back(f); else q1.push_back(f);
  endfunction
  function automatic void q_clear(input int u);
    if (u == 0) q0.delete(); else q1.delete();
  endfunction

  task automatic monitor(input int u);
    frame_t f;
    int last_end = 0, idle_bad = 0, es, good, fcnt = 0;
    bit after_frame = 0, aborted;
    forever begin
      @(negedge CLK);
      if (RST) begin
        q_clear(u); last_end = 0; idle_bad = 0; after_frame = 0;
        continue;
      end
      if (q_size(u) > 0) begin
        f = (u == 0) ? q0[0] : q1[0];
        es = (f.acc + LAT > last_end) ? f.acc + LAT : last_end;
        if (cyc > es) begin
          f = q_pop(u);
          check($sformatf("u%0d f%0d start missing at cycle", u, fcnt), cyc, es);
          fcnt++;
          continue;
        end
        if (cyc == es) begin
          f = q_pop(u);
          check($sformatf("u%0d f%0d idle samples bad before start", u, fcnt), idle_bad, 0);
          idle_bad = 0; after_frame = 0; aborted = 0;
          for (int b = 0; b < f.nbits && !aborted; b++) begin
            good = 0;
            for (int c = 0; c < CPB; c++) begin
              if (b != 0 || c != 0) @(negedge CLK);
              if (RST) begin aborted = 1; break; end
              if (line[u] === f.bits[b] && busyv[u] === 1'b1) good++;
            end
            if (!aborted)
              check($sformatf("u%0d f%0d bit%0d matching samples (want %0d)", u, fcnt, b, f.bits[b]),
                    good, CPB);
          end
          if (aborted) begin q_clear(u); last_end = 0; idle_bad = 0; end
          else begin last_end = es + f.nbits * CPB; after_frame = 1; end
          fcnt++;
          continue;
        end
      end
      if (after_frame) begin
        check($sformatf("u%0d busy after frame end", u), int'(busyv[u]), 0);
        after_frame = 0;
      end
      if (line[u] !== 1'b1 || busyv[u] !== 1'b0) idle_bad++;
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic set_inputs(input int u, input int data, input int pm, input bit st2, input bit v);
    if (u == 0) begin d0 = data[7:0]; pm0 = pm[1:0]; st0 = st2; v0 = v; end
    else        begin d1 = data[6:0]; pm1 = pm[1:0]; st1 = st2; v1 = v; end
  endtask

  task automatic send(input int u, input int data, input int pm, input bit st2);
    int n;
    @(negedge CLK);
    set_inputs(u, data, pm, st2, 1'b1);
    for (n = 0; n < 3000; n++) begin
      if (rdy[u]) break;
      @(negedge CLK);
    end
    if (n == 3000) begin
      check($sformatf("u%0d accept timeout", u), 0, 1);
      set_inputs(u, data, pm, st2, 1'b0);
      return;
    end
    last_acc = cyc + 1;
    q_push(u, model(data, (u == 0) ? 8 : 7, pm, st2, cyc + 1));
    @(posedge CLK); #1;
    // Scramble the idle inputs: only the values at load may affect the frame.
    set_inputs(u, $urandom_range(0, 255), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic wait_idle(input int u);
    int n;
    for (n = 0; n < 8000; n++) begin
      @(negedge CLK);
      if (q_size(u) == 0 && busyv[u] == 1'b0) break;
    end
    if (n == 8000) check($sformatf("u%0d drain timeout", u), 0, 1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic burst();
    int acc[6];
    int w[6];
    int i = 0, n = 0;
    for (int k = 0; k < 6; k++) w[k] = $urandom_range(0, 255);
    @(negedge CLK);
    set_inputs(0, w[0], 2, 1'b0, 1'b1);
    while (i < 6 && n < 5000) begin
      if (rdy0) begin
        q0.push_back(model(w[i], 8, 2, 1'b0, cyc + 1));
        acc[i] = cyc + 1;
        i++;
        @(posedge CLK); #1;
        if (i < 6) d0 = w[i][7:0]; else v0 = 1'b0;
        @(negedge CLK);
      end else begin
        @(negedge CLK);
        n++;
      end
    end
    v0 = 1'b0;
    check("burst words accepted", i, 6);
`ifdef UART_TX_FIFO_EN
    check("burst first five accepts consecutive", acc[4] - acc[0], 4);
    check("burst ready low after five accepts", int'((acc[5] - acc[4]) > 1), 1);
`else
    for (int k = 1; k < 6; k++)
      check($sformatf("burst accept spacing %0d", k), acc[k] - acc[k-1], 11 * CPB);
`endif
  endtask

  initial begin
    int target;
    // Valid during reset must be ignored.
    set_inputs(0, 'hA5, 2, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    check("reset dout", int'(dout0), 1);
    check("reset busy", int'(busy0), 0);
    check("reset ready u0", int'(rdy0), 0);
    check("reset ready u1", int'(rdy1), 0);
    @(posedge CLK); #1;
    RST = 1'b0; v0 = 1'b0;
    @(negedge CLK);
    check("ready after release", int'(rdy0), 1);
    repeat (4) @(negedge CLK);

    send(0, 'h41, 2, 1'b0);
    send(0, 'h41, 1, 1'b0);
    send(0, 'h55, 0, 1'b1);
    wait_idle(0);

    repeat (8) begin
      repeat ($urandom_range(0, 40)) @(negedge CLK);
      send(0, $urandom_range(0, 255), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    wait_idle(0);

    burst();
    wait_idle(0);

    // Reset during the third data bit.
    send(0, $urandom_range(0, 255), 2, 1'b0);
    target = last_acc + LAT + 3 * CPB + 5;
`ifdef UART_TX_FIFO_EN
    send(0, $urandom_range(0, 255), 1, 1'b0);
    send(0, $urandom_range(0, 255), 0, 1'b1);
`endif
    while (cyc < target) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("ready while reset held", int'(rdy0), 0);
    @(negedge CLK);
    check("dout after mid-frame reset", int'(dout0), 1);
    check("busy after mid-frame reset", int'(busy0), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("ready after mid-frame reset", int'(rdy0), 1);
    send(0, $urandom_range(0, 255), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    wait_idle(0);

    send(1, 'h7F, 2, 1'b0);
    repeat (4) begin
      repeat ($urandom_range(0, 20)) @(negedge CLK);
      send(1, $urandom_range(0, 127), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    wait_idle(1);
    wait_idle(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
